// File: rtl/cam_prio_enc.sv
// Priority encoder for the CAM match vector: picks the winning index and flags
// whether any match or more than one match is present.
module cam_prio_enc #(
   parameter int DEPTH    = 16,
   parameter bit PRI_HIGH = 1'b1,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]  vec,
   output logic [ADDR_W-1:0] index,
   output logic              any,
   output logic              multi
);

   always_comb begin
      index = '0;
      // Scan order is chosen so the last assignment is the preferred match.
      if (PRI_HIGH) begin
         for (int i = 0; i < DEPTH; i++)
            if (vec[i]) index = ADDR_W'(i);
      end else begin
         for (int i = DEPTH - 1; i >= 0; i--)
            if (vec[i]) index = ADDR_W'(i);
      end
   end

   assign any   = |vec;
   assign multi = |(vec & (vec - DEPTH'(1)));

endmodule

// File: rtl/param_cam.sv
// Parametrised ternary CAM: write-by-address, invalidate, masked search with a
// registered priority-encoded result and registered occupancy flags.
module param_cam #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter bit PRI_HIGH = 1'b1,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen,
   input  logic              ren,
   input  logic              inv,
   input  logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] mask,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] dout,
   output logic              hit,
   output logic              multi_hit,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  valid;
   logic [DEPTH-1:0]  valid_nxt;
   logic [DEPTH-1:0]  match;
   logic [ADDR_W-1:0] enc_index;
   logic              enc_any;
   logic              enc_multi;

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++)
         match[i] = valid[i] && (((mem[i] ^ din) & mask) == '0);
   end

   // Write is applied after invalidate so a same-cycle write leaves the entry valid.
   always_comb begin
      valid_nxt = valid;
      if (inv) valid_nxt[addr] = 1'b0;
      if (wen) valid_nxt[addr] = 1'b1;
   end

   cam_prio_enc #(
      .DEPTH    (DEPTH),
      .PRI_HIGH (PRI_HIGH)
   ) u_prio_enc (
      .vec   (match),
      .index (enc_index),
      .any   (enc_any),
      .multi (enc_multi)
   );

   // Entry data is deliberately not reset; the valid vector hides stale contents.
   always_ff @(posedge clk) begin
      if (rst_n && wen) mem[addr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid     <= '0;
         dout      <= '0;
         hit       <= 1'b0;
         multi_hit <= 1'b0;
         full      <= 1'b0;
         empty     <= 1'b1;
      end else begin
         valid     <= valid_nxt;
         dout      <= ren ? enc_index : '0;
         hit       <= ren & enc_any;
         multi_hit <= ren & enc_multi;
         full      <= &valid_nxt;
         empty     <= ~|valid_nxt;
      end
   end

endmodule

// File: tb/tb_param_cam.sv
// Bench for param_cam: drives a high-priority and a low-priority instance in
// lockstep and scores both against a reference model through a queue.
module tb_param_cam;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wen = 1'b0, ren = 1'b0, inv = 1'b0;
   logic [7:0] din = '0, mask = '0;
   logic [3:0] addr = '0;

   logic [3:0] dout_h, dout_l;
   logic       hit_h, hit_l, multi_h, multi_l, full_h, full_l, empty_h, empty_l;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] dout_h;
      logic [3:0] dout_l;
      logic       hit;
      logic       multi;
      logic       full;
      logic       empty;
   } exp_t;

   exp_t exp_q[$];

   logic [7:0] m_mem [16];
   logic       m_val [16];

   always #5 clk = ~clk;

   param_cam #(.DATA_W(8), .DEPTH(16), .PRI_HIGH(1'b1)) u_hi (
      .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .inv(inv),
      .din(din), .mask(mask), .addr(addr),
      .dout(dout_h), .hit(hit_h), .multi_hit(multi_h), .full(full_h), .empty(empty_h)
   );

   param_cam #(.DATA_W(8), .DEPTH(16), .PRI_HIGH(1'b0)) u_lo (
      .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .inv(inv),
      .din(din), .mask(mask), .addr(addr),
      .dout(dout_l), .hit(hit_l), .multi_hit(multi_l), .full(full_l), .empty(empty_l)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // One clock of stimulus; the model predicts the result before the edge.
   task automatic step(input logic r, input logic w, input logic s, input logic v,
                       input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
      exp_t e;
      int   cnt;
      rst_n = r; wen = w; ren = s; inv = v; addr = a; din = d; mask = m;
      e = '{dout_h: 4'd0, dout_l: 4'd0, hit: 1'b0, multi: 1'b0, full: 1'b0, empty: 1'b1};
      if (!r) begin
         for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
      end else begin
         cnt = 0;
         if (s) begin
            for (int i = 0; i < 16; i++) begin
               if (m_val[i] && (((m_mem[i] ^ d) & m) == 8'h00)) begin
                  if (cnt == 0) e.dout_l = 4'(i);
                  e.dout_h = 4'(i);
                  cnt++;
               end
            end
         end
         e.hit   = (cnt > 0);
         e.multi = (cnt > 1);
         if (v) m_val[a] = 1'b0;
         if (w) begin
            m_val[a] = 1'b1;
            m_mem[a] = d;
         end
         cnt = 0;
         for (int i = 0; i < 16; i++) if (m_val[i]) cnt++;
         e.full  = (cnt == 16);
         e.empty = (cnt == 0);
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_underflow", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("dout_hi",  32'(dout_h),  32'(e.dout_h));
         chk("dout_lo",  32'(dout_l),  32'(e.dout_l));
         chk("hit_hi",   32'(hit_h),   32'(e.hit));
         chk("hit_lo",   32'(hit_l),   32'(e.hit));
         chk("multi_hi", 32'(multi_h), 32'(e.multi));
         chk("multi_lo", 32'(multi_l), 32'(e.multi));
         chk("full",     32'(full_h),  32'(e.full));
         chk("empty",    32'(empty_l), 32'(e.empty));
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      step(1'b1, 1'b1, 1'b0, 1'b0, a, d, 8'h00);
   endtask

   task automatic sr(input logic [7:0] d, input logic [7:0] m);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, d, m);
   endtask

   task automatic iv(input logic [3:0] a);
      step(1'b1, 1'b0, 1'b0, 1'b1, a, 8'h00, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_mem[i] = 8'h00;
         m_val[i] = 1'b0;
      end

      step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      chk("rst_empty", 32'(empty_h), 32'd1);
      chk("rst_full",  32'(full_h),  32'd0);
      chk("rst_hit",   32'(hit_h),   32'd0);
      chk("rst_dout",  32'(dout_h),  32'd0);

      wr(4'd0, 8'd4); wr(4'd7, 8'd8); wr(4'd15, 8'd35); wr(4'd9, 8'd8); wr(4'd5, 8'd8);
      sr(8'd4, 8'hFF);
      chk("s4_dout", 32'(dout_h), 32'd0);  chk("s4_hit", 32'(hit_h), 32'd1);
      chk("s4_multi", 32'(multi_h), 32'd0);
      sr(8'd8, 8'hFF);
      chk("s8_dout_hi", 32'(dout_h), 32'd9); chk("s8_dout_lo", 32'(dout_l), 32'd5);
      chk("s8_multi", 32'(multi_h), 32'd1);
      sr(8'd35, 8'hFF);
      chk("s35_dout", 32'(dout_h), 32'd15); chk("s35_multi", 32'(multi_h), 32'd0);
      sr(8'd87, 8'hFF);
      chk("s87_hit", 32'(hit_h), 32'd0);
      sr(8'd45, 8'hFF);
      chk("s45_hit", 32'(hit_h), 32'd0);

      iv(4'd9);
      sr(8'd8, 8'hFF);
      chk("inv9_dout", 32'(dout_h), 32'd7); chk("inv9_multi", 32'(multi_h), 32'd1);
      iv(4'd7); iv(4'd5);
      sr(8'd8, 8'hFF);
      chk("inv75_hit", 32'(hit_h), 32'd0);
      sr(8'h20, 8'hF0);
      chk("mask_dout", 32'(dout_h), 32'd15); chk("mask_hit", 32'(hit_h), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h20, 8'hF0);
      chk("idle_hit", 32'(hit_h), 32'd0);

      step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 8'd99, 8'hFF);
      chk("rbw_hit", 32'(hit_h), 32'd0);
      sr(8'd99, 8'hFF);
      chk("rbw_dout", 32'(dout_h), 32'd3); chk("rbw_hit2", 32'(hit_h), 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 8'd77, 8'h00);
      sr(8'd77, 8'hFF);
      chk("wen_inv_dout", 32'(dout_h), 32'd3); chk("wen_inv_hit", 32'(hit_h), 32'd1);

      for (int i = 0; i < 16; i++) iv(4'(i));
      chk("all_inv_empty", 32'(empty_h), 32'd1);
      for (int i = 0; i < 15; i++) wr(4'(i), 8'(100 + i));
      chk("w15_full", 32'(full_h), 32'd0);
      wr(4'd15, 8'd115);
      chk("w16_full", 32'(full_h), 32'd1);
      iv(4'd4);
      chk("inv_full", 32'(full_h), 32'd0);
      sr(8'h00, 8'h00);
      chk("m0_dout_hi", 32'(dout_h), 32'd15); chk("m0_dout_lo", 32'(dout_l), 32'd0);
      chk("m0_multi", 32'(multi_h), 32'd1);

      for (int k = 0; k < 40; k++)
         step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

      wr(4'd2, 8'd110);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd110, 8'hFF);
      chk("rst_mid_hit", 32'(hit_h), 32'd0); chk("rst_mid_empty", 32'(empty_h), 32'd1);
      sr(8'd110, 8'hFF);
      chk("post_rst_hit", 32'(hit_h), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
